// File: rtl/sram_like_defs.sv
// ---------------------------------------------------------------------------
// sram_like_defs
// Shared definitions for the SRAM-like bus responder:
//   - size_e       : transfer size encodings on the req/addr_ok bus
//   - CNT_W        : width of the per-entry latency down-counter
//   - entry_t      : one outstanding-request entry {wr, rdata, cnt}
//   - LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR (16,14,13,11)
//   - lane_merge() : byte-strobe merge of write data into a stored word
//   - lfsr_next()  : one LFSR step
// ---------------------------------------------------------------------------
package sram_like_defs;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALF     = 2'd1,
        SIZE_WORD     = 2'd2,
        SIZE_WORD_ALT = 2'd3   // treated as a word transfer
    } size_e;

    localparam int DATA_W = 32;

    // LATENCY-1 (max 14) plus up to 3 random extra cycles needs 5 bits.
    localparam int CNT_W = 5;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] rdata;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// ---------------------------------------------------------------------------
// sram_like_resp_fifo
// In-order queue of outstanding requests. Every valid entry carries its own
// latency down-counter; the head may retire only once its counter is zero,
// so responses stay in order even when a younger entry finishes counting
// first.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   i_push, i_entry   enqueue one entry (caller guarantees room or a pop)
//   o_full            all DEPTH entries in use
//   o_head_ready      head valid and its counter expired; also the pop
//   o_head_wr         head entry is a write response
//   o_head_rdata      head entry captured read data
// ---------------------------------------------------------------------------
module sram_like_resp_fifo
    import sram_like_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_push,
    input  entry_t            i_entry,
    output logic              o_full,
    output logic              o_head_ready,
    output logic              o_head_wr,
    output logic [DATA_W-1:0] o_head_rdata
);

    localparam int PW = $clog2(DEPTH);

    logic              r_vld  [DEPTH];
    logic [CNT_W-1:0]  r_cnt  [DEPTH];
    logic              r_wr   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;

    logic w_pop;

    assign w_pop        = r_vld[r_head] && (r_cnt[r_head] == '0);
    assign o_head_ready = w_pop;
    assign o_full       = (r_count == (PW+1)'(DEPTH));
    assign o_head_wr    = r_wr[r_head];
    assign o_head_rdata = r_data[r_head];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_cnt[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            // Push follows pop so a full-queue push+pop into the slot just
            // freed leaves that slot valid.
            if (i_push) begin
                r_vld[r_tail] <= 1'b1;
                r_cnt[r_tail] <= i_entry.cnt;
                r_tail        <= r_tail + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is only meaningful while r_vld is set; no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_wr[r_tail]   <= i_entry.wr;
            r_data[r_tail] <= i_entry.rdata;
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// ---------------------------------------------------------------------------
// sram_like_responder
// Target end of the req/addr_ok/data_ok SRAM-like bus backed by a
// word-addressed RAM. Requests are accepted with addr_ok, writes commit to
// RAM on the accept edge, reads capture RAM on the accept edge, and
// responses (data_ok/rdata) come back strictly in order LATENCY cycles later
// or after older responses, whichever is later.
// Optional build macro: RESP_RANDOM_DELAY_EN -- a 16-bit LFSR throttles
// addr_ok and adds 0..3 cycles of response latency per request.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req, wr, size        request valid, write flag, transfer size (unused:
//                        wstrb is authoritative and rdata is a full word)
//   wstrb, addr, wdata   byte enables, byte address, lane-aligned write data
//   addr_ok              request accepted this cycle
//   data_ok, rdata       in-order response pulse, read data (0 for writes)
// ---------------------------------------------------------------------------
module sram_like_responder
    import sram_like_defs::*;
#(
    parameter int          MEM_AW    = 10,
    parameter int          DEPTH     = 4,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    logic [31:0]       r_mem [2**MEM_AW];

    logic [MEM_AW-1:0] w_idx;
    logic              w_full;
    logic              w_head_ready;
    logic              w_head_wr;
    logic [31:0]       w_head_rdata;
    logic              w_gate;
    logic [1:0]        w_extra;
    entry_t            w_entry;

    // Upper address bits alias onto the same RAM words.
    assign w_idx = addr[MEM_AW+1:2];

`ifdef RESP_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_gate  = r_lfsr[0];
    assign w_extra = r_lfsr[2:1];

    logic w_unused;
    assign w_unused = &{1'b0, size, addr[1:0], addr[31:MEM_AW+2]};
`else
    assign w_gate  = 1'b1;
    assign w_extra = 2'b00;

    logic w_unused;
    assign w_unused = &{1'b0, size, addr[1:0], addr[31:MEM_AW+2], LFSR_SEED};
`endif

    // A full queue can still accept when the head retires this cycle.
    assign addr_ok = resetn & req & (~w_full | w_head_ready) & w_gate;

    always_comb begin
        w_entry       = '0;
        w_entry.wr    = wr;
        w_entry.rdata = wr ? 32'h0 : r_mem[w_idx];
        w_entry.cnt   = CNT_W'(LATENCY - 1) + CNT_W'(w_extra);
    end

    always_ff @(posedge clk) begin
        if (addr_ok && wr) r_mem[w_idx] <= lane_merge(r_mem[w_idx], wdata, wstrb);
    end

    sram_like_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (addr_ok),
        .i_entry      (w_entry),
        .o_full       (w_full),
        .o_head_ready (w_head_ready),
        .o_head_wr    (w_head_wr),
        .o_head_rdata (w_head_rdata)
    );

    assign data_ok = w_head_ready;
    assign rdata   = (w_head_ready && !w_head_wr) ? w_head_rdata : 32'h0;

endmodule
